// File: rtl/fetch_unit.sv
// fetch_unit -- instruction-fetch stage.
//
// Owns the fetch PC, issues pipelined word requests to a latency-tolerant
// instruction memory, buffers returned words with their PCs in an in-order
// queue and hands them to decode over a valid/ready handshake. A redirect
// from execute flushes the queue and arranges for every response still in
// flight to be discarded on arrival.
//
// Ports
//   clk, rst          clock, asynchronous active-high reset
//   imem_req_*        request channel to instruction memory (valid/ready/addr)
//   imem_resp_*       in-order response channel (valid/instr), no backpressure
//   redirect_*        branch/jump redirect (one-cycle pulse + target)
//   if_*              decode channel (valid/ready/instr/pc)
//
// Build option
//   FETCH_BYPASS_EN   when defined, a response for an empty queue head is
//                     presented to decode in the cycle it arrives.

module fetch_unit #(
   parameter int unsigned     XLEN       = 32,
   parameter logic [XLEN-1:0] RESET_PC   = '0,
   parameter int unsigned     FIFO_DEPTH = 4
) (
   input  logic            clk,
   input  logic            rst,
   output logic            imem_req_valid,
   input  logic            imem_req_ready,
   output logic [XLEN-1:0] imem_req_addr,
   input  logic            imem_resp_valid,
   input  logic [31:0]     imem_resp_instr,
   input  logic            redirect_valid,
   input  logic [XLEN-1:0] redirect_pc,
   output logic            if_valid,
   input  logic            if_ready,
   output logic [31:0]     if_instr,
   output logic [XLEN-1:0] if_pc
);

   localparam int unsigned AW = $clog2(FIFO_DEPTH);
   localparam int unsigned PW = AW + 1;
   localparam logic [PW:0] DEPTH_W = (PW+1)'(FIFO_DEPTH);

   typedef logic [PW-1:0] ptr_t;

   logic [XLEN-1:0] fetch_pc_q, fetch_pc_d;
   ptr_t            alloc_q, alloc_d;
   ptr_t            fill_q, fill_d;
   ptr_t            read_q, read_d;
   ptr_t            drop_q, drop_d;

   logic [XLEN-1:0] pc_mem_q    [FIFO_DEPTH];
   logic [31:0]     instr_mem_q [FIFO_DEPTH];

   logic [PW:0]     used_w;
   logic            req_fire;
   logic            resp_keep;
   logic            head_filled;
   logic            head_avail;
   logic [31:0]     head_instr;
   logic            pop;
   logic [AW-1:0]   head_idx;
   logic            unused_redirect_lsbs;

   // The low address bits of a redirect target are forced to zero.
   assign unused_redirect_lsbs = ^redirect_pc[1:0];

   assign head_idx = read_q[AW-1:0];

   // Credit covers entries held in the queue (filled or awaiting their
   // response) plus responses still owed to requests killed by a redirect.
   assign used_w = {1'b0, ptr_t'(alloc_q - read_q)} + {1'b0, drop_q};

   assign imem_req_valid = !rst && !redirect_valid && (used_w < DEPTH_W);
   assign imem_req_addr  = fetch_pc_q;
   assign req_fire       = imem_req_valid && imem_req_ready;

   assign resp_keep   = imem_resp_valid && (drop_q == '0);

   // Responses arrive in order, so the head is filled exactly when the fill
   // pointer has moved past the read pointer.
   assign head_filled = (fill_q != read_q);

`ifdef FETCH_BYPASS_EN
   // With an empty head, the next kept response is the head's word.
   assign head_avail = head_filled || resp_keep;
   assign head_instr = head_filled ? instr_mem_q[head_idx] : imem_resp_instr;
`else
   assign head_avail = head_filled;
   assign head_instr = instr_mem_q[head_idx];
`endif

   assign if_valid = head_avail && !redirect_valid;
   assign if_instr = if_valid ? head_instr : '0;
   assign if_pc    = if_valid ? pc_mem_q[head_idx] : '0;
   assign pop      = if_valid && if_ready;

   always_comb begin
      fetch_pc_d = fetch_pc_q;
      alloc_d    = alloc_q;
      fill_d     = fill_q;
      read_d     = read_q;
      drop_d     = drop_q;
      if (redirect_valid) begin
         fetch_pc_d = {redirect_pc[XLEN-1:2], 2'b00};
         alloc_d    = '0;
         fill_d     = '0;
         read_d     = '0;
         // Everything owed from before this cycle becomes a drop, less the
         // response (stale by definition) that lands in this very cycle.
         drop_d     = drop_q + ptr_t'(alloc_q - fill_q)
                      - (imem_resp_valid ? ptr_t'(1) : ptr_t'(0));
      end else begin
         if (req_fire) begin
            fetch_pc_d = fetch_pc_q + XLEN'(4);
            alloc_d    = alloc_q + ptr_t'(1);
         end
         if (imem_resp_valid) begin
            if (drop_q != '0) drop_d = drop_q - ptr_t'(1);
            else              fill_d = fill_q + ptr_t'(1);
         end
         if (pop) read_d = read_q + ptr_t'(1);
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         fetch_pc_q <= RESET_PC;
         alloc_q    <= '0;
         fill_q     <= '0;
         read_q     <= '0;
         drop_q     <= '0;
      end else begin
         fetch_pc_q <= fetch_pc_d;
         alloc_q    <= alloc_d;
         fill_q     <= fill_d;
         read_q     <= read_d;
         drop_q     <= drop_d;
      end
   end

   // Queue storage needs no reset: decode outputs are masked until the
   // entry has been written.
   always_ff @(posedge clk) begin
      if (req_fire) pc_mem_q[alloc_q[AW-1:0]] <= imem_req_addr;
      if (resp_keep && !redirect_valid) instr_mem_q[fill_q[AW-1:0]] <= imem_resp_instr;
   end

endmodule

// File: tb/tb_fetch_unit.sv
module tb_fetch_unit;

   localparam int          XLEN  = 32;
   localparam int          DEPTH = 4;
   localparam logic [31:0] RPC   = 32'h0000_0100;
   localparam logic [31:0] KEY   = 32'hA5A5_0000;
`ifdef FETCH_BYPASS_EN
   localparam bit BYP = 1'b1;
`else
   localparam bit BYP = 1'b0;
`endif

   logic        clk = 1'b0;
   logic        rst;
   logic        imem_req_valid, imem_req_ready;
   logic [31:0] imem_req_addr;
   logic        imem_resp_valid;
   logic [31:0] imem_resp_instr;
   logic        redirect_valid;
   logic [31:0] redirect_pc;
   logic        if_valid, if_ready;
   logic [31:0] if_instr, if_pc;

   fetch_unit #(.XLEN(XLEN), .RESET_PC(RPC), .FIFO_DEPTH(DEPTH)) dut (
      .clk(clk), .rst(rst),
      .imem_req_valid(imem_req_valid), .imem_req_ready(imem_req_ready),
      .imem_req_addr(imem_req_addr),
      .imem_resp_valid(imem_resp_valid), .imem_resp_instr(imem_resp_instr),
      .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
      .if_valid(if_valid), .if_ready(if_ready),
      .if_instr(if_instr), .if_pc(if_pc)
   );

   always #5 clk = ~clk;

   int n_checks = 0;
   int n_pass   = 0;

   // Memory model: in-order queue of accepted requests with due cycle and
   // a flag marking responses that belong to a flushed stream.
   logic [31:0] q_addr  [$];
   int          q_due   [$];
   bit          q_stale [$];
   int          lat_min = 1;
   int          lat_max = 1;
   int          cyc     = 0;

   // Program-order model: next PC to request, next PC decode must see,
   // live entries (accepted since last redirect, not yet delivered) and
   // words returned but not yet delivered.
   logic [31:0] exp_req_pc, exp_del_pc;
   int          live, avail;

   // Logs of what the DUT actually did.
   int          n_acc, n_deliv;
   logic [31:0] acc_log [$];
   logic [31:0] del_log [$];
   int          del_cyc [$];

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      assert (obs === exp) n_pass++;
      else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
   endtask

   task automatic clear_logs();
      n_acc = 0; n_deliv = 0;
      acc_log.delete(); del_log.delete(); del_cyc.delete();
   endtask

   task automatic cycle(input bit rdy, input bit ifr, input bit redir, input logic [31:0] rpc);
      bit          rv, old_stale, rstale, exp_reqv, exp_ifv;
      logic [31:0] ri;
      int          n_stale;
      @(negedge clk);
      rv = 1'b0; ri = '0; old_stale = 1'b0;
      if (q_addr.size() > 0 && q_due[0] <= cyc) begin
         rv        = 1'b1;
         ri        = q_addr.pop_front() ^ KEY;
         old_stale = q_stale.pop_front();
         void'(q_due.pop_front());
      end
      rstale  = old_stale || redir;
      n_stale = (rv && old_stale) ? 1 : 0;
      foreach (q_stale[i]) if (q_stale[i]) n_stale++;

      imem_req_ready  = rdy;
      if_ready        = ifr;
      redirect_valid  = redir;
      redirect_pc     = rpc;
      imem_resp_valid = rv;
      imem_resp_instr = ri;
      #1;

      exp_reqv = !redir && (live + n_stale < DEPTH);
      exp_ifv  = !redir && (avail > 0 || (BYP && rv && !rstale));

      chk("req_valid", imem_req_valid, exp_reqv);
      chk("req_addr",  imem_req_addr,  exp_req_pc);
      chk("if_valid",  if_valid,       exp_ifv);
      if (exp_ifv) begin
         chk("if_pc",    if_pc,    exp_del_pc);
         chk("if_instr", if_instr, exp_del_pc ^ KEY);
      end

      if (imem_req_valid && rdy) begin n_acc++; acc_log.push_back(imem_req_addr); end
      if (if_valid && ifr) begin
         n_deliv++; del_log.push_back(if_pc); del_cyc.push_back(cyc);
      end

      if (redir) begin
         exp_req_pc = rpc & ~32'h3;
         exp_del_pc = rpc & ~32'h3;
         live  = 0;
         avail = 0;
         foreach (q_stale[i]) q_stale[i] = 1'b1;
      end else begin
         if (rv && !rstale) avail++;
         if (exp_ifv && ifr) begin exp_del_pc += 32'd4; avail--; live--; end
         if (exp_reqv && rdy) begin
            q_addr.push_back(exp_req_pc);
            q_due.push_back(cyc + int'($urandom_range(lat_max, lat_min)));
            q_stale.push_back(1'b0);
            exp_req_pc += 32'd4;
            live++;
         end
      end
      @(posedge clk);
      cyc++;
   endtask

   task automatic do_reset();
      @(negedge clk);
      #2 rst = 1'b1;
      #1;
      chk("rst_req_valid", imem_req_valid, 1'b0);
      chk("rst_if_valid",  if_valid,       1'b0);
      chk("rst_req_addr",  imem_req_addr,  RPC);
      chk("rst_if_pc",     if_pc,          32'h0);
      chk("rst_if_instr",  if_instr,       32'h0);
      imem_req_ready = 1'b0; if_ready = 1'b0; redirect_valid = 1'b0;
      redirect_pc = '0; imem_resp_valid = 1'b0; imem_resp_instr = '0;
      q_addr.delete(); q_due.delete(); q_stale.delete();
      exp_req_pc = RPC; exp_del_pc = RPC; live = 0; avail = 0;
      clear_logs();
      repeat (2) @(posedge clk);
      #2 rst = 1'b0;
   endtask

   int red_cyc;

   initial begin
      rst = 1'b1;
      imem_req_ready = 1'b0; if_ready = 1'b0; redirect_valid = 1'b0;
      redirect_pc = '0; imem_resp_valid = 1'b0; imem_resp_instr = '0;

      // Streaming, 1-cycle memory, decode always ready.
      lat_min = 1; lat_max = 1;
      do_reset();
      repeat (24) cycle(1'b1, 1'b1, 1'b0, '0);
      chk("t1_accepted",  n_acc,   24);
      chk("t1_delivered", n_deliv, BYP ? 23 : 22);
      chk("t1_first_pc",  (del_log.size() > 0) ? del_log[0] : 32'hDEAD_BEEF, RPC);

      // Decode stalled: queue fills to capacity, then drains in order.
      do_reset();
      repeat (10) cycle(1'b1, 1'b0, 1'b0, '0);
      chk("t2_accepted", n_acc, DEPTH);
      #1;
      chk("t2_req_stalled", imem_req_valid, 1'b0);
      chk("t2_held_addr",   imem_req_addr,  32'h110);
      repeat (12) cycle(1'b1, 1'b1, 1'b0, '0);
      chk("t2_resume_pc", (acc_log.size() > 4) ? acc_log[4] : 32'hDEAD_BEEF, 32'h110);

      // 3-cycle memory, redirect with two requests in flight.
      lat_min = 3; lat_max = 3;
      do_reset();
      repeat (2) cycle(1'b1, 1'b1, 1'b0, '0);
      chk("t3_outstanding", n_acc, 2);
      cycle(1'b1, 1'b1, 1'b1, 32'h0000_0203);
      repeat (12) cycle(1'b1, 1'b1, 1'b0, '0);
      chk("t3_first",  (del_log.size() > 0) ? del_log[0] : 32'hDEAD_BEEF, 32'h200);
      chk("t3_second", (del_log.size() > 1) ? del_log[1] : 32'hDEAD_BEEF, 32'h204);

      // Redirect colliding with a response and a pop; redirect latency.
      lat_min = 1; lat_max = 1;
      do_reset();
      repeat (6) cycle(1'b1, 1'b1, 1'b0, '0);
      clear_logs();
      red_cyc = cyc;
      cycle(1'b1, 1'b1, 1'b1, 32'h0000_0400);
      chk("t4_no_deliver_on_redirect", n_deliv, 0);
      repeat (8) cycle(1'b1, 1'b1, 1'b0, '0);
      chk("t4_latency", (del_cyc.size() > 0) ? del_cyc[0] - red_cyc : -1, BYP ? 2 : 3);
      chk("t4_pc", (del_log.size() > 0) ? del_log[0] : 32'hDEAD_BEEF, 32'h400);
      #1;
      chk("t4_drops_cleared", imem_req_valid, 1'b1);

      // Memory not ready holds the address; PC wraps past the top.
      do_reset();
      repeat (3) cycle(1'b0, 1'b1, 1'b0, '0);
      chk("t5_no_alloc", n_acc, 0);
      cycle(1'b1, 1'b1, 1'b1, 32'hFFFF_FFFC);
      repeat (6) cycle(1'b1, 1'b1, 1'b0, '0);
      chk("t5_top",  (acc_log.size() > 0) ? acc_log[0] : 32'hDEAD_BEEF, 32'hFFFF_FFFC);
      chk("t5_wrap", (acc_log.size() > 1) ? acc_log[1] : 32'hDEAD_BEEF, 32'h0);

      // Asynchronous reset mid-stream.
      lat_min = 2; lat_max = 2;
      do_reset();
      repeat (7) cycle(1'b1, 1'b1, 1'b0, '0);
      #1;
      chk("t6_pre_req_valid", imem_req_valid, 1'b1);
      do_reset();
      repeat (8) cycle(1'b1, 1'b1, 1'b0, '0);
      chk("t6_first_req", (acc_log.size() > 0) ? acc_log[0] : 32'hDEAD_BEEF, RPC);
      chk("t6_first_del", (del_log.size() > 0) ? del_log[0] : 32'hDEAD_BEEF, RPC);

      // Randomised traffic against the program-order model.
      lat_min = 1; lat_max = 4;
      do_reset();
      for (int i = 0; i < 3000; i++) begin
         bit          r_rdy, r_ifr, r_red;
         logic [31:0] r_pc;
         r_rdy = ($urandom_range(99, 0) < 75);
         r_ifr = ($urandom_range(99, 0) < 70);
         r_red = ($urandom_range(99, 0) < 3);
         r_pc  = $urandom;
         if ($urandom_range(9, 0) == 0) r_pc = 32'hFFFF_FFF0 | (r_pc & 32'hF);
         cycle(r_rdy, r_ifr, r_red, r_pc);
      end

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule

// File: doc/fetch_unit.md
Name: fetch_unit

Overview:
Parameterised instruction-fetch stage for the next-generation core. It replaces the single-cycle PC register and next-PC logic. It owns the fetch PC and issues pipelined requests to a latency-tolerant instruction memory. Returned words are buffered with their PCs in an in-order queue and handed to decode over a valid/ready handshake. Branch/jump redirects from execute flush the queue and discard in-flight stale responses.

Parameters:
XLEN, 32, address/PC width in bits
RESET_PC, 32'h0000_0000, first fetch address after reset
FIFO_DEPTH, 4, instruction buffer entries; power of two, >= 2; also the cap on buffered + outstanding requests

Ports:
clk  input  1  clock
rst  input  1  asynchronous, active-high reset
imem_req_valid  output  1  fetch request valid
imem_req_ready  input  1  IMEM accepts request
imem_req_addr  output  XLEN  word-aligned fetch address
imem_resp_valid  input  1  response valid; in order; earliest one cycle after acceptance
imem_resp_instr  input  32  returned instruction word
redirect_valid  input  1  branch/jump taken; flush and restart
redirect_pc  input  XLEN  redirect target; bits [1:0] ignored (treated as 0)
if_valid  output  1  instruction available to decode
if_ready  input  1  decode consumes
if_instr  output  32  instruction at queue head
if_pc  output  XLEN  PC of if_instr

Behaviour:
- Reset (async, while rst=1): fetch_pc=RESET_PC; alloc/fill/read pointers=0; drop_cnt=0. Outputs: imem_req_valid=0, imem_req_addr=RESET_PC, if_valid=0, if_instr=0, if_pc=0. First request can issue in the first clock after rst falls.
- Queue: circular FIFO_DEPTH entries {pc, instr, filled}. Three pointers, each with an extra wrap bit:
  - alloc: advances on request handshake; writes pc=imem_req_addr, filled=0.
  - fill: advances on each non-dropped response; writes instr, sets filled=1.
  - read: advances on if_valid && if_ready.
- Credit rule: imem_req_valid = !redirect_valid && (entries_allocated + drop_cnt) < FIFO_DEPTH. imem_req_addr = fetch_pc.
- Request handshake: imem_req_valid && imem_req_ready → fetch_pc <= fetch_pc + 4 (mod 2^XLEN, wrap allowed). While ready is low, addr is held stable.
- Decode handshake: if_valid = (head entry filled) && !redirect_valid; if_pc/if_instr come from the head entry. A pop frees the entry the next cycle.
- Response handling:
  - drop_cnt > 0: response discarded, drop_cnt decrements.
  - Otherwise: written to the fill pointer.
  - A response with no outstanding request is a protocol error; behaviour is undefined (bench asserts).
- Redirect (one cycle, highest priority):
  - All pointers reset to equal; fetch_pc <= {redirect_pc[XLEN-1:2], 2'b00}.
  - drop_cnt <= drop_cnt + (alloc - fill) - (resp_this_cycle ? 1 : 0). Every response for a request accepted before the redirect cycle is discarded.
  - No request is issued and no instruction is delivered in the redirect cycle.
- Latency with 1-cycle IMEM, redirect in cycle N: request at N+1 with redirect_pc, response N+2, if_valid N+3.
- Throughput: one instruction/cycle sustained when IMEM is always ready, latency 1, if_ready=1.
- Full: allocated + drop_cnt == FIFO_DEPTH → imem_req_valid=0. Empty: if_valid=0.
- Pop and response in the same cycle, including on the last/first entry, are both honoured.

Optional Feature:
FETCH_BYPASS_EN:
- Defined: when the queue has no filled head entry and a non-dropped response arrives for the head entry, if_valid/if_instr/if_pc present it combinationally in the same cycle. If if_ready=1 the entry is consumed without becoming visible from the queue. Redirect-to-if_valid latency drops to N+2.
- Undefined: responses always pass through the queue; one extra cycle of latency.

Test Plan:
1. RESET_PC=0x100, IMEM ready, 1-cycle latency returning instr=addr^0xA5A5_0000, if_ready=1 → if_pc 0x100,0x104,0x108,... one per cycle after initial latency, instr matches, none missing or duplicated.
2. if_ready=0, FIFO_DEPTH=4 → exactly 4 requests (0x100–0x10C), then imem_req_valid=0. Release if_ready → delivery in order, fetch resumes at 0x110.
3. IMEM latency 3, redirect_valid with redirect_pc=0x203 while 2 requests outstanding → both stale responses dropped. Next if_pc=0x200, then 0x204. No stale if_valid.
4. Redirect in the same cycle as a response and as if_valid&&if_ready → if_valid=0 that cycle; stale word never delivered; drop_cnt returns to 0.
5. imem_req_ready low 3 cycles → imem_req_addr constant, no allocation. Fetch PC 0xFFFF_FFFC → next request 0x0000_0000.
6. rst asserted mid-stream asynchronously → if_valid and imem_req_valid go low immediately. After release, the first request addr=RESET_PC and no pre-reset response is delivered.
